// File: rtl/pc_fetch_unit_pkg.sv
// Shared state encoding and datapath widths for the fetch stage.
package pc_fetch_unit_pkg;
  localparam int INSTR_W   = 32;
  localparam int ADDR_W    = 32;
  localparam int BR_OFF_W  = 16;
  localparam int JMP_IDX_W = 26;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;
endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Sequential PC increment and redirect target (jump or sign-extended branch).
// Purely combinational, no backpressure.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    id_pc_plus4,
  input  logic [BR_OFF_W-1:0]  br_offset,
  input  logic [JMP_IDX_W-1:0] jmp_index,
  input  logic                 select,
  output logic [ADDR_W-1:0]    pc_plus4,
  output logic [ADDR_W-1:0]    target
);
  logic [ADDR_W-1:0] br_disp;

  // Word offset becomes a byte displacement: sign-extend, then shift left by two.
  assign br_disp  = {{(ADDR_W-BR_OFF_W-2){br_offset[BR_OFF_W-1]}}, br_offset, 2'b00};
  assign pc_plus4 = pc + PC_STEP;
  assign target   = select ? {id_pc_plus4[ADDR_W-1:ADDR_W-4], jmp_index, 2'b00}
                           : id_pc_plus4 + br_disp;
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, registers (instr, pc, pc+4) one cycle after the address is presented,
// holds under id_ready backpressure, redirects with a one-cycle bubble and halts on an all-zero word.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]   imem_instr,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [INSTR_W-1:0]   id_instr,
  output logic [ADDR_W-1:0]    id_pc,
  output logic [ADDR_W-1:0]    id_pc_plus4,
  input  logic                 br_taken,
  input  logic [BR_OFF_W-1:0]  br_offset,
  input  logic                 jmp,
  input  logic [JMP_IDX_W-1:0] jmp_index,
  output logic                 halted,
  output logic [31:0]          fetch_count
);
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target;
  logic              fire;
  logic              load_ok;
  logic              redirect;
  logic              zero_hit;

  next_pc_calc u_next_pc (
    .pc          (pc),
    .id_pc_plus4 (id_pc_plus4),
    .br_offset   (br_offset),
    .jmp_index   (jmp_index),
    .select      (jmp),
    .pc_plus4    (pc_plus4),
    .target      (target)
  );

  assign imem_addr = pc;
  assign fire      = id_valid & id_ready;
  assign load_ok   = ~id_valid | fire;
  assign redirect  = fire & (jmp | br_taken);
  assign zero_hit  = load_ok & HALT_ON_ZERO & (imem_instr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          // The word at the old pc is wrong-path on a redirect, so it is dropped even if zero.
          if (redirect) begin
            pc       <= target;
            id_valid <= 1'b0;
          end else if (zero_hit) begin
            state  <= HALT;
            halted <= 1'b1;
            if (fire) id_valid <= 1'b0;
          end else if (load_ok) begin
            id_instr    <= imem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            pc          <= pc_plus4;
            if (fetch_count != '1) fetch_count <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          if (fire) id_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, id_ready, br_taken, jmp, id_valid, halted;
  logic [15:0] br_offset;
  logic [25:0] jmp_index;
  logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus4, fetch_count;
  logic [31:0] mem [0:255];

  logic        w_rst, w_start, w_id_valid, w_halted;
  logic [31:0] w_imem_addr, w_imem_instr, w_id_instr, w_id_pc, w_id_pc_plus4, w_fetch_count;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return (a < 32'd1024) ? mem[idx] : 32'h0;
  endfunction

  assign imem_instr   = mem_rd(imem_addr);
  assign w_imem_instr = (w_imem_addr == 32'h0) ? 32'h0 : ~w_imem_addr;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp),
    .jmp_index(jmp_index), .halted(halted), .fetch_count(fetch_count)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .HALT_ON_ZERO(1'b0)) dut_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .id_pc_plus4(w_id_pc_plus4), .br_taken(1'b0), .br_offset(16'h0), .jmp(1'b0),
    .jmp_index(26'h0), .halted(w_halted), .fetch_count(w_fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_cur;
  bit          model_halt;
  int          n_loaded;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Architectural model: the consumed stream is the program's execution order; a zero word ends it.
  task automatic model_enter(input logic [31:0] p);
    if (mem_rd(p) == 32'h0) begin
      model_halt = 1'b1;
    end else begin
      exp_q.push_back(exp_t'{pc: p, instr: mem_rd(p)});
      model_cur = p;
      n_loaded++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fire: got id_pc %h, required no valid instruction", id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("id_pc", id_pc, mon_e.pc);
        chk("id_instr", id_instr, mon_e.instr);
        chk("id_pc_plus4", id_pc_plus4, mon_e.pc + 32'd4);
      end
    end
  end

  task automatic drive_cycle(input bit allow_redir);
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    start     = 1'b0;
    id_ready  = ($urandom_range(0, 9) < 7);
    br_taken  = ($urandom_range(0, 3) == 0);
    jmp       = ($urandom_range(0, 5) == 0);
    br_offset = 16'($urandom);
    jmp_index = 26'($urandom);
    if (id_valid && id_ready && !model_halt) begin
      if (!allow_redir) begin
        br_taken = 1'b0;
        jmp      = 1'b0;
      end else begin
        br_offset = 16'($urandom_range(0, 16) - 8);
        jmp_index = 26'($urandom_range(0, 255));
      end
      if (jmp)
        nxt = ((model_cur + 32'd4) & 32'hF000_0000) | (32'(jmp_index) << 2);
      else if (br_taken)
        nxt = model_cur + 32'd4 + 32'($signed(br_offset)) * 32'd4;
      else
        nxt = model_cur + 32'd4;
      model_enter(nxt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit done, mid_reset;
    rst = 1'b1; start = 1'b0; id_ready = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    br_offset = 16'h0; jmp_index = 26'h0;
    w_rst = 1'b1; w_start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Wrap-around instance: PC 0xFFFFFFFC steps to 0; zero word is ordinary with HALT_ON_ZERO=0.
    @(posedge clk); #1;
    w_rst = 1'b0;
    chk("wrap_idle_addr", w_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_idle_valid", 32'(w_id_valid), 32'd0);
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    chk("wrap_valid_after_start_edge", 32'(w_id_valid), 32'd0);
    @(posedge clk); #1;
    chk("wrap_first_pc", w_id_pc, 32'hFFFF_FFFC);
    chk("wrap_first_instr", w_id_instr, 32'h0000_0003);
    chk("wrap_first_plus4", w_id_pc_plus4, 32'h0);
    chk("wrap_second_addr", w_imem_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap_second_pc", w_id_pc, 32'h0);
    chk("wrap_zero_loaded", w_id_instr, 32'h0);
    chk("wrap_not_halted", 32'(w_halted), 32'd0);
    chk("wrap_count", w_fetch_count, 32'd2);

    for (int run = 0; run < 12; run++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
      if (run == 0) mem[0] = 32'h0;
      @(posedge clk); #2;
      rst = 1'b1; start = 1'b0; id_ready = 1'b0;
      #1;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_id_pc", id_pc, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      model_halt = 1'b0;
      n_loaded = 0;
      @(posedge clk); #1;
      chk("idle_addr", imem_addr, 32'h0);
      chk("idle_valid", 32'(id_valid), 32'd0);
      start = 1'b1;
      model_enter(32'h0);

      done = 1'b0;
      mid_reset = 1'b0;
      for (int cyc = 0; cyc < 4000 && !done && !mid_reset; cyc++) begin
        drive_cycle(cyc < 300);
        if (model_halt && halted && !id_valid) done = 1'b1;
        if (run == 2 && cyc == 60) begin
          #2;
          rst = 1'b1;
          #1;
          chk("async_rst_valid", 32'(id_valid), 32'd0);
          chk("async_rst_addr", imem_addr, 32'h0);
          chk("async_rst_count", fetch_count, 32'd0);
          chk("async_rst_halted", 32'(halted), 32'd0);
          chk("async_rst_id_instr", id_instr, 32'h0);
          mid_reset = 1'b1;
        end
      end
      if (!mid_reset) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL run_timeout: got halted=%0d id_valid=%0d, required halt within budget",
                   halted, id_valid);
        end else begin
          chk("end_halted", 32'(halted), 32'd1);
          chk("end_count", fetch_count, 32'(n_loaded));
          chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
